nrn_mac: RTL

Multiply-accumulate stage of the neuron datapath, directly downstream of data fetch. Consumes one weight/input pair per `df_rdy` cycle and accumulates a fixed number of signed fixed-point products. Adds a bias, rescales, optionally applies ReLU and saturates. Presents one neuron result per group of N_IN terms with a one-cycle `out_rdy` strobe.

---
 rtl/nrn_mac_if.sv | 30 +++
 rtl/nrn_mac.sv | 120 ++++++++++++
 2 files changed

// File: rtl/nrn_mac_if.sv
// Upstream/downstream signal bundle of the neuron MAC stage.
// Handshake: df_rdy marks data_w/data_i as valid in the cycle it is high and
// there is no backpressure, so the MAC takes every flagged pair; out_rdy is a
// one-cycle strobe that data_out/ovf carry a new result, which the consumer
// must take in that cycle. clear aborts the group in progress.
interface nrn_mac_if #(
    parameter int DATA_W = 16
);
    logic              clear;
    logic              df_rdy;
    logic [DATA_W-1:0] data_w;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] bias;
    logic [DATA_W-1:0] data_out;
    logic              out_rdy;
    logic              ovf;
    logic              busy;

    // Producer/consumer side (data fetch and result sink).
    modport master (
        output clear, df_rdy, data_w, data_i, bias,
        input  data_out, out_rdy, ovf, busy
    );

    // MAC side.
    modport slave (
        input  clear, df_rdy, data_w, data_i, bias,
        output data_out, out_rdy, ovf, busy
    );
endinterface

// File: rtl/nrn_mac.sv
// Neuron multiply-accumulate stage: a product register (stage P) feeding an
// accumulator (stage A). The bias is folded in when the first product of a
// group reaches the accumulator, so consecutive groups run without bubbles.
// The final sum is rescaled, optionally ReLU-clamped and saturated.
module nrn_mac #(
    parameter int N_IN   = 7,
    parameter int DATA_W = 16,
    parameter int FRAC   = 8,
    parameter int RELU   = 0,
    parameter int ACC_W  = 2*DATA_W+4
) (
    input  logic   clk,
    input  logic   reset,
    nrn_mac_if.slave mac
);
    localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN-1);

    // Output range limits, expressed at accumulator width for direct compare.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    // Stage P state.
    logic [CNT_W-1:0]           cnt;
    logic signed [2*DATA_W-1:0] prod_q;
    logic                       pv_q;
    logic                       plast_q;

    // Stage A state.
    logic signed [ACC_W-1:0]    acc;
    logic                       first;
    logic [DATA_W-1:0]          data_out_q;
    logic                       ovf_q;
    logic                       out_rdy_q;

    // Combinational datapath of stage A.
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_base;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [ACC_W-1:0]    scaled;
    logic [DATA_W-1:0]          sat_res;
    logic                       sat_flag;

    assign bias_ext = {{(ACC_W-DATA_W){mac.bias[DATA_W-1]}}, mac.bias};
    assign prod_ext = {{(ACC_W-2*DATA_W){prod_q[2*DATA_W-1]}}, prod_q};

    // Sum, rescale (floor), optional ReLU and saturation of the running group.
    always_comb begin
        acc_base = first ? (bias_ext <<< FRAC) : acc;
        acc_next = acc_base + prod_ext;
        scaled   = acc_next >>> FRAC;
        if ((RELU != 0) && scaled[ACC_W-1]) begin
            scaled = '0;
        end
        sat_res  = scaled[DATA_W-1:0];
        sat_flag = 1'b0;
        if (scaled > SAT_MAX) begin
            sat_res  = {1'b0, {(DATA_W-1){1'b1}}};
            sat_flag = 1'b1;
        end else if (scaled < SAT_MIN) begin
            sat_res  = {1'b1, {(DATA_W-1){1'b0}}};
            sat_flag = 1'b1;
        end
    end

    // Stage P: register the product of each accepted pair and track the term index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            prod_q  <= '0;
            pv_q    <= 1'b0;
            plast_q <= 1'b0;
        end else if (mac.clear) begin
            cnt  <= '0;
            pv_q <= 1'b0;
        end else if (mac.df_rdy) begin
            prod_q  <= $signed(mac.data_w) * $signed(mac.data_i);
            pv_q    <= 1'b1;
            plast_q <= (cnt == CNT_LAST);
            cnt     <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end else begin
            pv_q <= 1'b0;
        end
    end

    // Stage A: accumulate, and on the last term of a group publish the result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc        <= '0;
            first      <= 1'b1;
            data_out_q <= '0;
            ovf_q      <= 1'b0;
            out_rdy_q  <= 1'b0;
        end else if (mac.clear) begin
            first     <= 1'b1;
            out_rdy_q <= 1'b0;
        end else begin
            out_rdy_q <= 1'b0;
            if (pv_q) begin
                if (plast_q) begin
                    first      <= 1'b1;
                    data_out_q <= sat_res;
                    ovf_q      <= sat_flag;
                    out_rdy_q  <= 1'b1;
                end else begin
                    acc   <= acc_next;
                    first <= 1'b0;
                end
            end
        end
    end

    assign mac.data_out = data_out_q;
    assign mac.ovf      = ovf_q;
    assign mac.out_rdy  = out_rdy_q;
    assign mac.busy     = (cnt != '0) || pv_q;

endmodule
